// File: rtl/ads1672_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ads1672_pkg : register map, bit positions and sample type         |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
package ads1672_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_THRESH = 2'd3;

  localparam int STAT_OVF   = 31;
  localparam int STAT_FULL  = 30;
  localparam int STAT_EMPTY = 29;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_CLR_OVF = 2;

  typedef logic signed [23:0] ads1672_sample_t;

endpackage
`default_nettype wire

// File: rtl/ads1672_fifo_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ads1672_fifo_mem : simple dual-port RAM, registered read output    |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module ads1672_fifo_mem #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Read-before-write: a pop of the slot being overwritten returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/ads1672_sample_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ads1672_sample_fifo : ADC sample FIFO behind an Avalon-MM slave    |
// | Rev 1.0 ; irq/THRESH logic built only with ADS1672_FIFO_IRQ_EN     |
// +------------------------------------------------------------------+
module ads1672_sample_fifo
  import ads1672_pkg::*;
#(
  parameter int ADC_DATA_WIDTH = 24,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADC_DATA_WIDTH-1:0] sample_in,
  input  logic                      sample_valid,
  input  logic [1:0]                address,
  input  logic                      read,
  input  logic                      write,
  input  logic [DATA_WIDTH-1:0]     writedata,
  output logic [DATA_WIDTH-1:0]     readdata,
  output logic                      irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  enable_q, enable_d;
  logic                  overflow_q, overflow_d;
  logic                  data_sel_q, data_sel_d;
  logic [DATA_WIDTH-1:0] reg_rd_q, reg_rd_d;
  logic [DATA_WIDTH-1:0] status;
  logic [CW-1:0]         thresh_rd;
  logic [ADC_DATA_WIDTH-1:0] ram_q;

  logic full, empty, pop_req, pop_ok, ctrl_wr, flush, push_req, push_ok;
  logic unused_writedata;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign pop_req  = read && (address == REG_DATA);
  assign pop_ok   = pop_req && !empty;
  assign ctrl_wr  = write && (address == REG_CTRL);
  assign flush    = ctrl_wr && writedata[CTRL_FLUSH];
  assign push_req = sample_valid && enable_q && !flush;
  // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
  assign push_ok  = push_req && (!full || pop_ok);

  assign unused_writedata = ^writedata;

  always_comb begin
    status             = '0;
    status[STAT_OVF]   = overflow_q;
    status[STAT_FULL]  = full;
    status[STAT_EMPTY] = empty;
    status[15:0]       = 16'(count_q);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_comb begin
    enable_d   = ctrl_wr ? writedata[CTRL_EN] : enable_q;
    overflow_d = overflow_q;
    if (ctrl_wr && writedata[CTRL_CLR_OVF]) overflow_d = 1'b0;
    if (push_req && full && !pop_ok)        overflow_d = 1'b1;
  end

  // Register-sourced reads are captured here; DATA pops come from the RAM port.
  always_comb begin
    data_sel_d = data_sel_q;
    reg_rd_d   = reg_rd_q;
    if (read) begin
      data_sel_d = pop_ok;
      case (address)
        REG_STATUS: reg_rd_d = status;
        REG_CTRL:   reg_rd_d = DATA_WIDTH'(enable_q);
        REG_THRESH: reg_rd_d = DATA_WIDTH'(thresh_rd);
        default:    reg_rd_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      enable_q   <= 1'b0;
      overflow_q <= 1'b0;
      data_sel_q <= 1'b0;
      reg_rd_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      enable_q   <= enable_d;
      overflow_q <= overflow_d;
      data_sel_q <= data_sel_d;
      reg_rd_q   <= reg_rd_d;
    end
  end

  ads1672_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ADC_DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (sample_in),
    .re    (pop_ok),
    .raddr (rd_ptr_q),
    .rdata (ram_q)
  );

  assign readdata = data_sel_q
                  ? {{(DATA_WIDTH-ADC_DATA_WIDTH){ram_q[ADC_DATA_WIDTH-1]}}, ram_q}
                  : reg_rd_q;

`ifdef ADS1672_FIFO_IRQ_EN
  logic [CW-1:0] thresh_q, thresh_d;
  logic [15:0]   thresh_wr;
  logic          irq_q, irq_d;

  always_comb begin
    thresh_wr = writedata[15:0];
    thresh_d  = thresh_q;
    if (write && (address == REG_THRESH))
      thresh_d = (thresh_wr > 16'(DEPTH)) ? DEPTH_C : thresh_wr[CW-1:0];
    irq_d = ((count_q >= thresh_q) && (thresh_q != '0)) || overflow_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thresh_q <= CW'(DEPTH / 2);
      irq_q    <= 1'b0;
    end else begin
      thresh_q <= thresh_d;
      irq_q    <= irq_d;
    end
  end

  assign thresh_rd = thresh_q;
  assign irq       = irq_q;
`else
  assign thresh_rd = '0;
  assign irq       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ads1672_sample_fifo.sv
`default_nettype none
// Randomised bench for ads1672_sample_fifo against a queue-based register model.
`timescale 1ns/1ps
module tb_ads1672_sample_fifo;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] sample_in;
  logic        sample_valid;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  always #5 clk = ~clk;

  ads1672_sample_fifo #(
    .ADC_DATA_WIDTH (24),
    .DATA_WIDTH     (32),
    .DEPTH          (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .readdata     (readdata),
    .irq          (irq)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [23:0] q[$];
  bit          m_ovf, m_en;
  int          m_thr;
  logic [31:0] exp_rd;
  logic        exp_irq;

  function automatic logic [31:0] sext(input logic [23:0] s);
    logic signed [31:0] v;
    v = $signed(s);
    return v;
  endfunction

  function automatic logic [31:0] status_word();
    return {m_ovf, q.size() == DEPTH, q.size() == 0, 13'd0, 16'(q.size())};
  endfunction

  function automatic logic [31:0] thresh_word();
`ifdef ADS1672_FIFO_IRQ_EN
    return 32'(m_thr);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic irq_now();
`ifdef ADS1672_FIFO_IRQ_EN
    return ((q.size() >= m_thr) && (m_thr != 0)) || m_ovf;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_en = 0; m_thr = DEPTH / 2;
    exp_rd = '0; exp_irq = 1'b0;
  endtask

  task automatic idle_inputs();
    sample_valid = 0; sample_in = '0; read = 0; address = '0; write = 0; writedata = '0;
  endtask

  // One bus/ADC clock: drive at a falling edge, update the model, return at the next falling edge.
  task automatic cycle(input bit sv, input logic [23:0] s, input bit rd,
                       input logic [1:0] a, input bit wr, input logic [31:0] wd);
    int pre;
    bit pop_ok, old_en, flush;
    sample_valid = sv; sample_in = s; read = rd; address = a; write = wr; writedata = wd;
    exp_irq = irq_now();
    pre     = q.size();
    old_en  = m_en;
    pop_ok  = rd && (a == 2'd0) && (pre > 0);
    if (rd) begin
      case (a)
        2'd0: exp_rd = pop_ok ? sext(q[0]) : 32'd0;
        2'd1: exp_rd = status_word();
        2'd2: exp_rd = {31'd0, m_en};
        default: exp_rd = thresh_word();
      endcase
    end
    if (pop_ok) void'(q.pop_front());
    flush = wr && (a == 2'd2) && wd[1];
    if (wr && a == 2'd2) begin
      if (wd[1]) q.delete();
      if (wd[2]) m_ovf = 0;
      m_en = wd[0];
    end
`ifdef ADS1672_FIFO_IRQ_EN
    if (wr && a == 2'd3) m_thr = (wd[15:0] > DEPTH) ? DEPTH : int'(wd[15:0]);
`endif
    if (sv && old_en && !flush) begin
      if (pre < DEPTH || pop_ok) q.push_back(s);
      else m_ovf = 1;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if (readdata !== 32'd0) begin n_err++; $display("FAIL reset_readdata got %h want 0", readdata); end
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", irq); end
    rst = 1'b0;
    cycle(0, 0, 1, 2'd1, 0, 0);
    n_vec++;
    if (readdata !== 32'h2000_0000) begin n_err++; $display("FAIL reset_status got %h want 20000000", readdata); end
    cycle(0, 0, 1, 2'd2, 0, 0);
    n_vec++;
    if (readdata !== 32'd0) begin n_err++; $display("FAIL reset_ctrl got %h want 0", readdata); end
  endtask

  task automatic test_sign_ext();
    logic [23:0] v[3];
    logic [31:0] w[3];
    v[0] = 24'h7FFFFF; v[1] = 24'h800000; v[2] = 24'h000001;
    w[0] = 32'h007FFFFF; w[1] = 32'hFF800000; w[2] = 32'h00000001;
    cycle(0, 0, 0, 2'd2, 1, 32'd1);
    for (int i = 0; i < 3; i++) cycle(1, v[i], 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 2'd0, 0, 0);
      n_vec++;
      if (readdata !== w[i]) begin n_err++; $display("FAIL sext_%0d got %h want %h", i, readdata, w[i]); end
    end
    cycle(0, 0, 1, 2'd1, 0, 0);
    n_vec++;
    if (readdata !== exp_rd || readdata[29] !== 1'b1)
      begin n_err++; $display("FAIL sext_empty got %h want %h", readdata, exp_rd); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH + 3; i++) cycle(1, 24'($urandom()), 0, 0, 0, 0);
    cycle(0, 0, 1, 2'd1, 0, 0);
    n_vec++;
    if (readdata !== 32'hC000_0000 + DEPTH)
      begin n_err++; $display("FAIL ovf_status got %h want %h", readdata, 32'hC000_0000 + DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 0, 1, 2'd0, 0, 0);
      n_vec++;
      if (readdata !== exp_rd) begin n_err++; $display("FAIL ovf_pop_%0d got %h want %h", i, readdata, exp_rd); end
    end
    cycle(0, 0, 0, 2'd2, 1, 32'h5);
    cycle(0, 0, 1, 2'd1, 0, 0);
    n_vec++;
    if (readdata !== 32'h2000_0000) begin n_err++; $display("FAIL ovf_clear got %h want 20000000", readdata); end
  endtask

  task automatic test_full_push_pop();
    logic [23:0] oldest;
    for (int i = 0; i < DEPTH; i++) cycle(1, 24'($urandom()), 0, 0, 0, 0);
    oldest = q[0];
    cycle(1, 24'($urandom()), 1, 2'd0, 0, 0);
    n_vec++;
    if (readdata !== sext(oldest)) begin n_err++; $display("FAIL full_pp_data got %h want %h", readdata, sext(oldest)); end
    cycle(0, 0, 1, 2'd1, 0, 0);
    n_vec++;
    if (readdata !== 32'h4000_0000 + DEPTH)
      begin n_err++; $display("FAIL full_pp_status got %h want %h", readdata, 32'h4000_0000 + DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 0, 1, 2'd0, 0, 0);
      n_vec++;
      if (readdata !== exp_rd) begin n_err++; $display("FAIL full_drain_%0d got %h want %h", i, readdata, exp_rd); end
    end
  endtask

  task automatic test_empty();
    logic [23:0] s;
    s = 24'($urandom());
    cycle(0, 0, 1, 2'd0, 0, 0);
    n_vec++;
    if (readdata !== 32'd0) begin n_err++; $display("FAIL empty_pop got %h want 0", readdata); end
    cycle(1, s, 1, 2'd0, 0, 0);
    n_vec++;
    if (readdata !== 32'd0) begin n_err++; $display("FAIL empty_pp_data got %h want 0", readdata); end
    cycle(0, 0, 1, 2'd1, 0, 0);
    n_vec++;
    if (readdata !== 32'd1) begin n_err++; $display("FAIL empty_pp_status got %h want 1", readdata); end
    cycle(0, 0, 1, 2'd0, 0, 0);
    n_vec++;
    if (readdata !== sext(s)) begin n_err++; $display("FAIL empty_pp_pop got %h want %h", readdata, sext(s)); end
  endtask

  task automatic test_flush();
    logic [23:0] s;
    for (int i = 0; i < DEPTH + 1; i++) cycle(1, 24'($urandom()), 0, 0, 0, 0);
    cycle(0, 0, 1, 2'd0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 24'($urandom()), 0, 0, 0, 0);
    cycle(1, 24'h123456, 0, 2'd2, 1, 32'h7);
    cycle(0, 0, 1, 2'd1, 0, 0);
    n_vec++;
    if (readdata !== 32'h2000_0000) begin n_err++; $display("FAIL flush_status got %h want 20000000", readdata); end
    cycle(0, 0, 1, 2'd2, 0, 0);
    n_vec++;
    if (readdata !== 32'd1) begin n_err++; $display("FAIL flush_ctrl got %h want 1", readdata); end
    s = 24'($urandom());
    cycle(1, s, 0, 0, 0, 0);
    cycle(0, 0, 1, 2'd0, 0, 0);
    n_vec++;
    if (readdata !== sext(s)) begin n_err++; $display("FAIL flush_next got %h want %h", readdata, sext(s)); end
  endtask

  task automatic test_irq();
    cycle(0, 0, 0, 2'd3, 1, 32'd4);
    cycle(0, 0, 1, 2'd3, 0, 0);
    n_vec++;
    if (readdata !== exp_rd) begin n_err++; $display("FAIL irq_thresh got %h want %h", readdata, exp_rd); end
    for (int i = 0; i < 6; i++) begin
      if (i < 4) cycle(1, 24'($urandom()), 0, 0, 0, 0);
      else if (i == 4) cycle(0, 0, 0, 0, 0, 0);
      else cycle(0, 0, 1, 2'd0, 0, 0);
      n_vec++;
      if (irq !== exp_irq) begin n_err++; $display("FAIL irq_step_%0d got %b want %b", i, irq, exp_irq); end
    end
    cycle(0, 0, 0, 0, 0, 0);
    n_vec++;
    if (irq !== exp_irq) begin n_err++; $display("FAIL irq_after_pop got %b want %b", irq, exp_irq); end
    cycle(0, 0, 0, 2'd3, 1, 32'd1000);
    cycle(0, 0, 1, 2'd3, 0, 0);
    n_vec++;
    if (readdata !== exp_rd) begin n_err++; $display("FAIL irq_sat got %h want %h", readdata, exp_rd); end
    cycle(0, 0, 0, 2'd3, 1, 32'd2);
    for (int i = 0; i < 3; i++) cycle(1, 24'($urandom()), 0, 0, 0, 0);
    sample_valid = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (irq !== 1'b0 || readdata !== 32'd0)
      begin n_err++; $display("FAIL irq_midreset got irq=%b rd=%h want 0/0", irq, readdata); end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    bit sv, rd, wr;
    logic [1:0] a;
    logic [31:0] wd;
    int rd_pct;
    cycle(0, 0, 0, 2'd2, 1, 32'd1);
    for (int c = 0; c < 600; c++) begin
      rd_pct = (c % 200 < 100) ? 20 : 75;
      sv = ($urandom_range(0, 99) < 60);
      wr = ($urandom_range(0, 99) < 3);
      rd = !wr && ($urandom_range(0, 99) < rd_pct);
      a  = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
      wd = 32'($urandom());
      if (wr && a != 2'd3) begin
        a  = 2'd2;
        wd = {29'd0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0)};
      end else if (wr) wd = 32'($urandom_range(0, 80));
      cycle(sv, 24'($urandom()), rd, a, wr, wd);
      n_vec++;
      if (readdata !== exp_rd) begin n_err++; $display("FAIL rand_rd_%0d got %h want %h", c, readdata, exp_rd); end
      n_vec++;
      if (irq !== exp_irq) begin n_err++; $display("FAIL rand_irq_%0d got %b want %b", c, irq, exp_irq); end
    end
  endtask

  initial begin
    test_reset();
    test_sign_ext();
    test_overflow();
    test_full_push_pop();
    test_empty();
    test_flush();
    test_irq();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
